noc_inject_arbiter: RTL and testbench

- Round-robin arbiter that shares one router injection port among NUM_SRC core-side flit sources.
- Each source presents an 11-bit flit (| 7-bit Hamming(7,4) payload [10:4] | 4-bit address [3:0] |) with a valid/ready handshake.
- The winning flit is registered into a single output stage that drives the router input.
- Sits between the per-core encoders and the router's local input channel.

---
 rtl/noc_inject_arbiter.sv | 110 +++++++++++
 tb/tb_noc_inject_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: round-robin arbiter sharing one router injection port among NUM_SRC sources.
// Optional Hamming(7,4) single-bit correction in the load path, enabled by defining PARITY_FIX_EN.
module noc_inject_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int FLIT_W  = 11,
  parameter int SRC_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        req_valid,
  input  logic [NUM_SRC*FLIT_W-1:0] req_data,
  output logic [NUM_SRC-1:0]        req_ready,
  output logic                      out_valid,
  output logic [FLIT_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready,
  output logic [7:0]                err_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t               state;
  logic [SRC_W-1:0]     rr_ptr;
  logic                 can_load;
  logic                 grant;
  logic [2*NUM_SRC-1:0] req_dbl;
  logic [NUM_SRC-1:0]   req_rot;
  int                   win_idx;
  logic [SRC_W-1:0]     win;
  logic [SRC_W-1:0]     win_next;
  logic [FLIT_W-1:0]    win_data;
  logic [FLIT_W-1:0]    load_data;

  assign can_load = (state == EMPTY) | out_ready;

  // Rotate the request vector so that bit 0 corresponds to rr_ptr.
  assign req_dbl = {req_valid, req_valid} >> rr_ptr;
  assign req_rot = req_dbl[NUM_SRC-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    req_ready = '0;
    grant     = 1'b0;
    win_idx   = 0;
    win_data  = '0;
    // Descending scan: the lowest rotated offset overwrites last and wins.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_idx = int'(rr_ptr) + k;
        grant   = can_load;
      end
    end
    if (win_idx >= NUM_SRC) win_idx = win_idx - NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant && (i == win_idx)) begin
        req_ready[i] = 1'b1;
        win_data     = req_data[i*FLIT_W +: FLIT_W];
      end
    end
    win      = SRC_W'(win_idx);
    win_next = (win_idx == NUM_SRC - 1) ? '0 : SRC_W'(win_idx + 1);
  end

`ifdef PARITY_FIX_EN
  logic [6:0] pay;
  logic [2:0] syn;
  logic [6:0] flip_mask;

  assign pay       = win_data[10:4];
  assign syn       = {pay[3] ^ pay[4] ^ pay[5] ^ pay[6],
                      pay[1] ^ pay[2] ^ pay[5] ^ pay[6],
                      pay[0] ^ pay[2] ^ pay[4] ^ pay[6]};
  // Syndrome value s names the erroneous position, i.e. payload bit s-1.
  assign flip_mask = (syn == 3'd0) ? 7'd0 : (7'd1 << (syn - 3'd1));
  assign load_data = {pay ^ flip_mask, win_data[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (grant && (syn != 3'd0) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign load_data = win_data;
  assign err_cnt   = 8'd0;
`endif

  // Output stage: a grant always loads (covering simultaneous drain and load);
  // otherwise an accepted flit empties the stage while out_data keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_src  <= '0;
      rr_ptr   <= '0;
    end else if (grant) begin
      state    <= FULL;
      out_data <= load_data;
      out_src  <= win;
      rr_ptr   <= win_next;
    end else if (out_ready) begin
      state    <= EMPTY;
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Testbench for noc_inject_arbiter: directed scenarios plus randomized traffic against a queue-level model.
module tb_noc_inject_arbiter;

  localparam int N  = 4;
  localparam int W  = 11;
  localparam int SW = 2;
`ifdef PARITY_FIX_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_ready;
  logic [7:0]     err_cnt;

  int total = 0;
  int bad   = 0;

  noc_inject_arbiter #(.NUM_SRC(N), .FLIT_W(W), .SRC_W(SW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .out_ready(out_ready),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Hamming(7,4) encoder: data nibble on p2,p4,p5,p6; parity on p0,p1,p3.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] p;
    p    = '0;
    p[2] = d[0];
    p[4] = d[1];
    p[5] = d[2];
    p[6] = d[3];
    p[0] = p[2] ^ p[4] ^ p[6];
    p[1] = p[2] ^ p[5] ^ p[6];
    p[3] = p[4] ^ p[5] ^ p[6];
    return p;
  endfunction

  task automatic do_reset();
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got %h want 000", out_data); end
    total++; if (out_src !== '0) begin bad++; $display("FAIL reset_src got %0d want 0", out_src); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err got %0d want 0", err_cnt); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [W-1:0] exp_d;
    do_reset();
    @(negedge clk);
    req_valid          = 4'b0100;
    req_data[2*W +: W] = 11'h5A3;
    out_ready          = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got %b want 0100", req_ready); end
    @(posedge clk); #1;
    // Payload 0x5A has syndrome 4, so the corrected flit flips payload bit 3.
    exp_d = FIX ? 11'h523 : 11'h5A3;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got %b want 1", out_valid); end
    total++; if (out_data !== exp_d) begin bad++; $display("FAIL single_data got %h want %h", out_data, exp_d); end
    total++; if (out_src !== 2'd2) begin bad++; $display("FAIL single_src got %0d want 2", out_src); end
    total++; if (err_cnt !== (FIX ? 8'd1 : 8'd0)) begin bad++; $display("FAIL single_err got %0d want %0d", err_cnt, FIX ? 1 : 0); end
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL single_rrptr got %b want 1000", req_ready); end
    @(posedge clk); #1;
    total++; if (out_src !== 2'd3) begin bad++; $display("FAIL single_next_src got %0d want 3", out_src); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_r;
    do_reset();
    @(negedge clk);
    req_data  = {N{11'h556}};
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      exp_r        = '0;
      exp_r[c % N] = 1'b1;
      #1;
      total++; if (req_ready !== exp_r) begin bad++; $display("FAIL fair_ready cycle %0d got %b want %b", c, req_ready, exp_r); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_src !== SW'(c % N)) begin
        bad++; $display("FAIL fair_src cycle %0d got v=%b src=%0d want v=1 src=%0d", c, out_valid, out_src, c % N);
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    req_data           = {N{11'h00C}};
    req_data[1*W +: W] = 11'h556;
    req_valid          = 4'b0010;
    out_ready          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b1111;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready !== '0) begin bad++; $display("FAIL bp_ready cycle %0d got %b want 0000", c, req_ready); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 11'h556) begin
        bad++; $display("FAIL bp_hold cycle %0d got v=%b src=%0d data=%h want v=1 src=1 data=556", c, out_valid, out_src, out_data);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_release_ready got %b want 0100", req_ready); end
    @(posedge clk); #1;
    total++; if (out_src !== 2'd2 || out_data !== 11'h00C) begin
      bad++; $display("FAIL bp_release got src=%0d data=%h want src=2 data=00C", out_src, out_data);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    req_data  = {N{11'h556}};
    req_valid = 4'b1111;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_src !== 2'd1) begin
      bad++; $display("FAIL areset_pre got v=%b src=%0d want v=1 src=1", out_valid, out_src);
    end
    @(negedge clk);
    req_valid = '0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_src !== '0 || out_data !== '0) begin
      bad++; $display("FAIL areset_mid got v=%b src=%0d data=%h want v=0 src=0 data=000", out_valid, out_src, out_data);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL areset_ready got %b want 0001", req_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin
      bad++; $display("FAIL areset_first got v=%b src=%0d want v=1 src=0", out_valid, out_src);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_parity();
    logic [W-1:0] exp_d;
    do_reset();
    @(negedge clk);
    // Codeword 7'b1010101 with p4 flipped -> 7'b1000101, address 3.
    req_data[0 +: W] = 11'h453;
    req_valid        = 4'b0001;
    out_ready        = 1'b1;
    @(posedge clk); #1;
    exp_d = FIX ? 11'h553 : 11'h453;
    total++; if (out_data !== exp_d) begin bad++; $display("FAIL parity_fix got %h want %h", out_data, exp_d); end
    total++; if (out_data[3:0] !== 4'h3) begin bad++; $display("FAIL parity_addr got %h want 3", out_data[3:0]); end
    total++; if (err_cnt !== (FIX ? 8'd1 : 8'd0)) begin bad++; $display("FAIL parity_err got %0d want %0d", err_cnt, FIX ? 1 : 0); end
    @(negedge clk);
    req_data[0 +: W] = 11'h556;
    @(posedge clk); #1;
    total++; if (out_data !== 11'h556) begin bad++; $display("FAIL parity_clean_data got %h want 556", out_data); end
    total++; if (err_cnt !== (FIX ? 8'd1 : 8'd0)) begin bad++; $display("FAIL parity_clean_err got %0d want %0d", err_cnt, FIX ? 1 : 0); end
    @(negedge clk);
    req_data[0 +: W] = 11'h453;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (i == 252) begin
        #1;
        total++; if (err_cnt !== (FIX ? 8'd254 : 8'd0)) begin bad++; $display("FAIL parity_254 got %0d want %0d", err_cnt, FIX ? 254 : 0); end
      end
    end
    #1;
    total++; if (err_cnt !== (FIX ? 8'd255 : 8'd0)) begin bad++; $display("FAIL parity_sat got %0d want %0d", err_cnt, FIX ? 255 : 0); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [W-1:0] raw   [N];
    logic [W-1:0] clean [N];
    bit           corr  [N];
    logic [N-1:0] exp_r;
    logic [6:0]   p;
    logic [6:0]   mask;
    logic [3:0]   a;
    logic [W-1:0] m_data;
    bit           m_valid;
    int           m_rr, m_src, m_err, w, pos;
    do_reset();
    m_rr = 0; m_valid = 1'b0; m_data = '0; m_src = 0; m_err = 0; pend = '0;
    for (int i = 0; i < N; i++) begin raw[i] = '0; clean[i] = '0; corr[i] = 1'b0; end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          p        = encode(4'($urandom));
          a        = 4'($urandom);
          clean[i] = {p, a};
          corr[i]  = ($urandom_range(0, 2) == 0);
          pos      = $urandom_range(0, 6);
          mask     = 7'd1 << pos;
          raw[i]   = corr[i] ? {p ^ mask, a} : clean[i];
          pend[i]  = 1'b1;
        end
        req_data[i*W +: W] = raw[i];
      end
      req_valid = pend;
      out_ready = ($urandom_range(0, 3) != 0);
      w = -1;
      if (!m_valid || out_ready) begin
        for (int k = 0; k < N; k++) if (w < 0 && pend[(m_rr + k) % N]) w = (m_rr + k) % N;
      end
      exp_r = '0;
      if (w >= 0) exp_r[w] = 1'b1;
      #1;
      total++; if (req_ready !== exp_r) begin bad++; $display("FAIL rand_ready cycle %0d got %b want %b", c, req_ready, exp_r); end
      @(posedge clk); #1;
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = FIX ? clean[w] : raw[w];
        m_src   = w;
        m_rr    = (w + 1) % N;
        if (FIX && corr[w] && m_err < 255) m_err++;
        pend[w] = 1'b0;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      total++; if (out_valid !== m_valid || out_data !== m_data || out_src !== SW'(m_src) || err_cnt !== 8'(m_err)) begin
        bad++;
        $display("FAIL rand_out cycle %0d got v=%b d=%h s=%0d e=%0d want v=%b d=%h s=%0d e=%0d",
                 c, out_valid, out_data, out_src, err_cnt, m_valid, m_data, m_src, m_err);
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_async_reset();
    test_parity();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
